nonce_tx_queue: RTL

NONCE_TX_QUEUE -- requirements
Module: nonce_tx_queue

---
 rtl/nonce_tx_queue.sv | 68 ++++++
 1 files changed

// File: rtl/nonce_tx_queue.sv
// nonce_tx_queue: FIFO of golden nonces feeding a serial word transmitter with a send/busy handshake.
// Optional NONCE_DEDUP_EN drops a nonce equal to the last one accepted.
module nonce_tx_queue #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  nonce_valid,
    input  logic [31:0]           nonce,
    input  logic                  busy,
    output logic                  send,
    output logic [31:0]           word,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] ptr_one = 1;
    localparam logic [DEPTH_LOG2:0] cnt_one = 1;
    typedef enum logic [1:0] {IDLE, ARM, DRAIN} state_t;
    state_t state, state_nx;
    logic [31:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic pop, push, dup;
`ifdef NONCE_DEDUP_EN
    logic [31:0] last;
    logic last_valid;
    assign dup = last_valid && nonce == last;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            last       <= '0;
            last_valid <= 1'b0;
        end else if (push) begin
            last       <= nonce;
            last_valid <= 1'b1;
        end
`else
    assign dup = 1'b0;
`endif
    // a full FIFO still accepts when the head leaves on the same edge
    always_comb begin
        pop      = state == IDLE && count != '0 && !busy;
        push     = nonce_valid && !dup && (!count[DEPTH_LOG2] || pop);
        state_nx = (state == IDLE && pop)   ? ARM   :
                   (state == ARM && busy)   ? DRAIN :
                   (state == DRAIN && !busy) ? IDLE : state;
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= nonce;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            send     <= 1'b0;
            word     <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            send     <= pop;
            word     <= pop ? mem[rd_ptr] : word;
            wr_ptr   <= push ? wr_ptr + ptr_one : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + ptr_one : rd_ptr;
            count    <= (push && !pop) ? count + cnt_one :
                        (pop && !push) ? count - cnt_one : count;
            overflow <= overflow | (nonce_valid && !dup && !push);
        end
endmodule
